// File: rtl/csc_pipe.sv
// Streaming RGB -> grey / BT.601 full-range YCbCr / pass-through converter, 3-stage valid/ready pipeline.
// Optional feature macro: CSC_ROUND_EN (round-half-up before the Q8 shift; truncation when undefined).
module csc_pipe #(
  parameter int CH_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [3*CH_W-1:0]   src_data,
  output logic                dst_valid,
  input  logic                dst_ready,
  output logic [3*CH_W-1:0]   dst_data
);

  localparam int DW = 3 * CH_W;
  localparam int PW = CH_W + 10;
  localparam int SW = CH_W + 11;

`ifdef CSC_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(128);
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif
  localparam logic signed [SW-1:0] OFF  = SW'(1 << (CH_W - 1));
  localparam logic signed [SW-1:0] MAXV = SW'((1 << CH_W) - 1);

  // Row-major Q0.8 matrix: rows Y, Cb, Cr; columns R, G, B.
  function automatic logic signed [8:0] coef(input int idx);
    case (idx)
      0:       coef = 9'sd77;
      1:       coef = 9'sd150;
      2:       coef = 9'sd29;
      3:       coef = -9'sd43;
      4:       coef = -9'sd85;
      5:       coef = 9'sd128;
      6:       coef = 9'sd128;
      7:       coef = -9'sd107;
      default: coef = -9'sd21;
    endcase
  endfunction

  function automatic logic [CH_W-1:0] scale_clamp(input logic signed [SW-1:0] s,
                                                   input logic add_off);
    logic signed [SW-1:0] t;
    t = (s + RND) >>> 8;
    if (add_off) t = t + OFF;
    if (t[SW-1])       scale_clamp = '0;
    else if (t > MAXV) scale_clamp = '1;
    else               scale_clamp = t[CH_W-1:0];
  endfunction

  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [1:0]           mode1_q, mode1_d, mode2_q, mode2_d;
  logic [DW-1:0]        raw1_q, raw1_d, raw2_q, raw2_d, out3_q, out3_d;
  logic signed [PW-1:0] prod_q [9];
  logic signed [PW-1:0] prod_d [9];
  logic signed [PW-1:0] prod_mul [9];
  logic signed [SW-1:0] sum_q [3];
  logic signed [SW-1:0] sum_d [3];
  logic signed [SW-1:0] sum_add [3];
  logic                 adv1, adv2, adv3;
  logic                 load1, load2, load3;
  logic [CH_W-1:0]      y_c, cb_c, cr_c;

  for (genvar gi = 0; gi < 9; gi++) begin : g_mul
    logic [CH_W-1:0]      chan;
    logic signed [8:0]    c9;
    logic signed [PW-1:0] chan_ext, coef_ext;
    assign chan     = src_data[DW-1-(gi%3)*CH_W -: CH_W];
    assign c9       = coef(gi);
    assign chan_ext = signed'({{(PW-CH_W){1'b0}}, chan});
    assign coef_ext = {{(PW-9){c9[8]}}, c9};
    assign prod_mul[gi] = chan_ext * coef_ext;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_sum
    assign sum_add[gi] = SW'(prod_q[3*gi]) + SW'(prod_q[3*gi+1]) + SW'(prod_q[3*gi+2]);
  end

  assign y_c  = scale_clamp(sum_q[0], 1'b0);
  assign cb_c = scale_clamp(sum_q[1], 1'b1);
  assign cr_c = scale_clamp(sum_q[2], 1'b1);

  always_comb begin
    adv3  = !v3_q || dst_ready;
    adv2  = !v2_q || adv3;
    adv1  = !v1_q || adv2;
    load1 = adv1 && src_valid;
    load2 = adv2 && v1_q;
    load3 = adv3 && v2_q;

    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    mode1_d = mode1_q;
    mode2_d = mode2_q;
    raw1_d  = raw1_q;
    raw2_d  = raw2_q;
    out3_d  = out3_q;
    for (int i = 0; i < 9; i++) prod_d[i] = prod_q[i];
    for (int i = 0; i < 3; i++) sum_d[i] = sum_q[i];

    if (adv1) v1_d = src_valid;
    if (adv2) v2_d = v1_q;
    if (adv3) v3_d = v2_q;

    if (load1) begin
      mode1_d = mode;
      raw1_d  = src_data;
      for (int i = 0; i < 9; i++) prod_d[i] = prod_mul[i];
    end
    if (load2) begin
      mode2_d = mode1_q;
      raw2_d  = raw1_q;
      for (int i = 0; i < 3; i++) sum_d[i] = sum_add[i];
    end
    // Output register only updates on advance, so a stalled pixel stays put.
    if (load3) begin
      case (mode2_q)
        2'd0:    out3_d = {y_c, y_c, y_c};
        2'd1:    out3_d = {y_c, cb_c, cr_c};
        default: out3_d = raw2_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      mode1_q <= '0;
      mode2_q <= '0;
      raw1_q  <= '0;
      raw2_q  <= '0;
      out3_q  <= '0;
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int i = 0; i < 3; i++) sum_q[i] <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      mode1_q <= mode1_d;
      mode2_q <= mode2_d;
      raw1_q  <= raw1_d;
      raw2_q  <= raw2_d;
      out3_q  <= out3_d;
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      for (int i = 0; i < 3; i++) sum_q[i] <= sum_d[i];
    end
  end

  assign src_ready = rst_n && adv1;
  assign dst_valid = v3_q;
  assign dst_data  = out3_q;

endmodule

// File: tb/tb_csc_pipe.sv
// Self-checking bench for csc_pipe: directed test-plan steps plus random traffic against a scoreboard model.
module tb_csc_pipe;
  localparam int CH_W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        src_valid;
  logic        src_ready;
  logic [23:0] src_data;
  logic        dst_valid;
  logic        dst_ready;
  logic [23:0] dst_data;

  always #5 clk = ~clk;

  csc_pipe #(.CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_in = 0;
  int          n_out = 0;
  int          cyc = 0;
  bit          auto_rand = 0;
  logic [23:0] exp_q[$];
  logic [23:0] out_log[$];
  int          out_cyc[$];

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Reference: plain integer BT.601 arithmetic; >>> on int is floor division by 256.
  function automatic logic [23:0] ref_model(input logic [23:0] px, input logic [1:0] m);
    int r, g, b, rnd, y, cb, cr;
    logic [7:0] y8, cb8, cr8;
    r = int'(px[23:16]);
    g = int'(px[15:8]);
    b = int'(px[7:0]);
`ifdef CSC_ROUND_EN
    rnd = 128;
`else
    rnd = 0;
`endif
    y  = sat((77*r + 150*g + 29*b + rnd) >>> 8);
    cb = sat(((-43*r - 85*g + 128*b + rnd) >>> 8) + 128);
    cr = sat(((128*r - 107*g - 21*b + rnd) >>> 8) + 128);
    y8 = 8'(y); cb8 = 8'(cb); cr8 = 8'(cr);
    case (m)
      2'd0:    return {y8, y8, y8};
      2'd1:    return {y8, cb8, cr8};
      default: return px;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: score transfers happening at the coming edge, then step to #1 after it.
  task automatic cycle();
    bit sf, df;
    logic [23:0] e;
    #1;
    sf = src_valid && src_ready;
    df = dst_valid && dst_ready;
    if (df) begin
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", 32'(dst_data), 32'(e));
      end
      out_log.push_back(dst_data);
      out_cyc.push_back(cyc);
      n_out++;
    end
    if (sf) begin
      exp_q.push_back(ref_model(src_data, mode));
      n_in++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (sf && auto_rand) begin
      src_data = 24'($urandom);
      mode     = 2'($urandom_range(0, 3));
    end
  endtask

  // Single pixel into an empty pipe: transfer-in at edge N, dst_valid high from edge N+2, out at N+3.
  task automatic send_one(input logic [23:0] px, input logic [1:0] m, input string tag);
    dst_ready = 1'b1;
    src_valid = 1'b1;
    src_data  = px;
    mode      = m;
    #1;
    check({tag, "_src_ready"}, 32'(src_ready), 32'd1);
    cycle();
    src_valid = 1'b0;
    check({tag, "_lat1"}, 32'(dst_valid), 32'd0);
    cycle();
    check({tag, "_lat2"}, 32'(dst_valid), 32'd0);
    cycle();
    check({tag, "_lat3"}, 32'(dst_valid), 32'd1);
    check({tag, "_val"}, 32'(dst_data), 32'(ref_model(px, m)));
    cycle();
  endtask

  task automatic stream3(input logic [23:0] p0, input logic [1:0] m0,
                         input logic [23:0] p1, input logic [1:0] m1,
                         input logic [23:0] p2, input logic [1:0] m2);
    out_log.delete();
    out_cyc.delete();
    dst_ready = 1'b1;
    src_valid = 1'b1;
    src_data = p0; mode = m0; cycle();
    src_data = p1; mode = m1; cycle();
    src_data = p2; mode = m2; cycle();
    src_valid = 1'b0;
    repeat (4) cycle();
  endtask

  initial begin
    int k, base_in, base_out;
    logic [23:0] exp_s [4];
    logic [23:0] exp_m [3];

    rst_n = 1'b0; mode = 2'd0; src_valid = 1'b0; src_data = '0; dst_ready = 1'b0;
    repeat (2) cycle();
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_dst_valid", 32'(dst_valid), 32'd0);
    check("rst_dst_data", 32'(dst_data), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_src_ready", 32'(src_ready), 32'd1);

    send_one(24'hFFFFFF, 2'd0, "grey_white");
    send_one(24'hFF0000, 2'd1, "ycc_red");

`ifdef CSC_ROUND_EN
    exp_s[0] = 24'hFFFFFF; exp_s[1] = 24'h4D4D4D; exp_s[2] = 24'h4D55FF; exp_s[3] = 24'h1DFF6B;
    exp_m[0] = 24'h123456; exp_m[1] = 24'h4D4D4D; exp_m[2] = 24'h4D55FF;
`else
    exp_s[0] = 24'hFFFFFF; exp_s[1] = 24'h4C4C4C; exp_s[2] = 24'h4C55FF; exp_s[3] = 24'h1CFF6B;
    exp_m[0] = 24'h123456; exp_m[1] = 24'h4C4C4C; exp_m[2] = 24'h4C55FF;
`endif
    // Fixed test-plan constants, independent of the model.
    out_log.delete();
    dst_ready = 1'b1; src_valid = 1'b1;
    src_data = 24'hFFFFFF; mode = 2'd0; cycle();
    src_data = 24'hFF0000; mode = 2'd0; cycle();
    src_data = 24'hFF0000; mode = 2'd1; cycle();
    src_data = 24'h0000FF; mode = 2'd1; cycle();
    src_valid = 1'b0;
    repeat (4) cycle();
    check("const_count", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < out_log.size()) check($sformatf("const_px%0d", i), 32'(out_log[i]), 32'(exp_s[i]));

    stream3(24'h123456, 2'd2, 24'hFF0000, 2'd0, 24'hFF0000, 2'd1);
    check("mode_sw_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("mode_sw_px%0d", i), 32'(out_log[i]), 32'(exp_m[i]));
      check("mode_sw_consec1", 32'(out_cyc[1] - out_cyc[0]), 32'd1);
      check("mode_sw_consec2", 32'(out_cyc[2] - out_cyc[1]), 32'd1);
    end

    // Backpressure: 5 pixels offered, sink stalled for 6 cycles.
    base_in = n_in; base_out = n_out;
    auto_rand = 1;
    src_data = 24'($urandom); mode = 2'($urandom_range(0, 3));
    dst_ready = 1'b0; src_valid = 1'b1;
    repeat (6) begin
      cycle();
      if (dst_valid && exp_q.size() != 0) check("stall_hold", 32'(dst_data), 32'(exp_q[0]));
    end
    check("bp_accepts", 32'(n_in - base_in), 32'd3);
    check("bp_src_ready", 32'(src_ready), 32'd0);
    dst_ready = 1'b1;
    k = 0;
    while ((n_in - base_in) < 5 && k < 20) begin cycle(); k++; end
    src_valid = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin cycle(); k++; end
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_out_count", 32'(n_out - base_out), 32'd5);

    // Fill, then single-cycle dst_ready pulses with src_valid held.
    dst_ready = 1'b0; src_valid = 1'b1;
    k = 0;
    while (src_ready && k < 10) begin cycle(); k++; end
    check("full_occ", 32'(exp_q.size()), 32'd3);
    repeat (4) begin
      base_in = n_in; base_out = n_out;
      dst_ready = 1'b1;
      #1;
      check("simul_src_ready", 32'(src_ready), 32'd1);
      cycle();
      dst_ready = 1'b0;
      #1;
      check("simul_in", 32'(n_in - base_in), 32'd1);
      check("simul_out", 32'(n_out - base_out), 32'd1);
      check("simul_occ", 32'(exp_q.size()), 32'd3);
      check("simul_full", 32'(src_ready), 32'd0);
    end

    // Reset with 3 pixels in flight.
    auto_rand = 0;
    src_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    exp_q.delete();
    check("midrst_dst_valid", 32'(dst_valid), 32'd0);
    check("midrst_dst_data", 32'(dst_data), 32'd0);
    rst_n = 1'b1;
    dst_ready = 1'b1;
    repeat (5) begin
      cycle();
      check("midrst_no_stale", 32'(dst_valid), 32'd0);
    end
    send_one(24'($urandom), 2'($urandom_range(0, 3)), "post_rst");

    // Random traffic.
    repeat (300) begin
      src_valid = 1'($urandom_range(0, 1));
      dst_ready = ($urandom_range(0, 3) != 0);
      src_data  = 24'($urandom);
      mode      = 2'($urandom_range(0, 3));
      cycle();
    end
    src_valid = 1'b0;
    dst_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin cycle(); k++; end
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
